dmem_ldst_arbiter: RTL and testbench

Arbitrates data-memory load/store requests from NUM_REQ requesters onto a single shared data-memory command port. Requesters are TPU Scalar_Unit/Vector_Unit ldst ports. Grants use round-robin priority. A grant is held for the whole burst: the block counts data beats until the requested length completes, then releases and re-arbitrates. It sits between the TPU load/store command outputs and the DMem controller, and it owns grant/ready sequencing.

---
 rtl/dmem_ldst_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_ldst_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ldst_arbiter.sv
// Round-robin arbiter that hands the shared data-memory command port to one
// load/store requester at a time and holds the grant until its burst completes.
module dmem_ldst_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH_ADDR = 16,
    parameter int WIDTH_LEN  = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            I_Req,
    input  logic [NUM_REQ-1:0]            I_St,
    input  logic [NUM_REQ*WIDTH_ADDR-1:0] I_Addr,
    input  logic [NUM_REQ*WIDTH_LEN-1:0]  I_Len,
    output logic [NUM_REQ-1:0]            O_Grant,
    output logic [NUM_REQ-1:0]            O_Done,
    output logic                          O_Mem_Req,
    output logic                          O_Mem_St,
    output logic [WIDTH_ADDR-1:0]         O_Mem_Addr,
    output logic [WIDTH_LEN-1:0]          O_Mem_Len,
    input  logic                          I_Mem_Ack,
    input  logic                          I_Mem_Beat,
    output logic                          O_Busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, CMD, XFER, DONE} state_t;

    state_t                  state_reg;
    logic [PTR_W-1:0]        ptr_reg;
    logic [PTR_W-1:0]        gidx_reg;
    logic [WIDTH_LEN-1:0]    remain_reg;
    logic [NUM_REQ-1:0]      grant_reg;
    logic [NUM_REQ-1:0]      done_reg;
    logic                    mem_req_reg;
    logic                    mem_st_reg;
    logic [WIDTH_ADDR-1:0]   mem_addr_reg;
    logic [WIDTH_LEN-1:0]    mem_len_reg;

    logic [WIDTH_ADDR-1:0]   addr_arr [NUM_REQ];
    logic [WIDTH_LEN-1:0]    len_arr  [NUM_REQ];
    logic [PTR_W-1:0]        cand_idx [NUM_REQ];
    logic [PTR_W-1:0]        sel_idx;
    logic                    sel_valid;
    logic [PTR_W-1:0]        ptr_next;

    // cand_idx[k] is the requester searched k-th, i.e. (ptr + k) mod NUM_REQ
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [PTR_W:0] sum;
            assign addr_arr[gi] = I_Addr[gi*WIDTH_ADDR +: WIDTH_ADDR];
            assign len_arr[gi]  = I_Len[gi*WIDTH_LEN +: WIDTH_LEN];
            assign sum          = {1'b0, ptr_reg} + (PTR_W+1)'(gi);
            assign cand_idx[gi] = (sum >= (PTR_W+1)'(NUM_REQ))
                                ? PTR_W'(sum - (PTR_W+1)'(NUM_REQ))
                                : sum[PTR_W-1:0];
        end
    endgenerate

    always_comb begin
        sel_idx   = '0;
        sel_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (I_Req[cand_idx[k]]) begin
                sel_idx   = cand_idx[k];
                sel_valid = 1'b1;
            end
        end
    end

    assign ptr_next = (gidx_reg == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_reg + PTR_W'(1);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            gidx_reg     <= '0;
            remain_reg   <= '0;
            grant_reg    <= '0;
            done_reg     <= '0;
            mem_req_reg  <= 1'b0;
            mem_st_reg   <= 1'b0;
            mem_addr_reg <= '0;
            mem_len_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sel_valid) begin
                        gidx_reg     <= sel_idx;
                        grant_reg    <= NUM_REQ'(1) << sel_idx;
                        mem_st_reg   <= I_St[sel_idx];
                        mem_addr_reg <= addr_arr[sel_idx];
                        mem_len_reg  <= len_arr[sel_idx];
                        if (len_arr[sel_idx] != '0) begin
                            mem_req_reg <= 1'b1;
                            state_reg   <= CMD;
                        end else begin
                            state_reg   <= DONE;
                        end
                    end
                end
                CMD: begin
                    if (I_Mem_Ack) begin
                        mem_req_reg <= 1'b0;
                        remain_reg  <= mem_len_reg;
                        state_reg   <= XFER;
                    end
                end
                XFER: begin
                    if (I_Mem_Beat) begin
                        remain_reg <= remain_reg - WIDTH_LEN'(1);
                        if (remain_reg == WIDTH_LEN'(1)) begin
                            done_reg  <= grant_reg;
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    // A zero-length grant arrives here with done_reg clear and
                    // spends one extra cycle so the grant is visible before the pulse.
                    if (done_reg == '0) begin
                        done_reg <= grant_reg;
                    end else begin
                        done_reg  <= '0;
                        grant_reg <= '0;
                        ptr_reg   <= ptr_next;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign O_Grant    = grant_reg;
    assign O_Done     = done_reg;
    assign O_Mem_Req  = mem_req_reg;
    assign O_Mem_St   = mem_st_reg;
    assign O_Mem_Addr = mem_addr_reg;
    assign O_Mem_Len  = mem_len_reg;
    assign O_Busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_dmem_ldst_arbiter.sv
// Scenario bench for dmem_ldst_arbiter: directed scenarios plus randomized
// transactions compared against a round-robin reference model.
module tb_dmem_ldst_arbiter;

    localparam int NR = 4;
    localparam int WA = 16;
    localparam int WL = 8;

    logic              clock;
    logic              reset;
    logic [NR-1:0]     I_Req;
    logic [NR-1:0]     I_St;
    logic [NR*WA-1:0]  I_Addr;
    logic [NR*WL-1:0]  I_Len;
    logic [NR-1:0]     O_Grant;
    logic [NR-1:0]     O_Done;
    logic              O_Mem_Req;
    logic              O_Mem_St;
    logic [WA-1:0]     O_Mem_Addr;
    logic [WL-1:0]     O_Mem_Len;
    logic              I_Mem_Ack;
    logic              I_Mem_Beat;
    logic              O_Busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_ptr   = 0;

    dmem_ldst_arbiter #(.NUM_REQ(NR), .WIDTH_ADDR(WA), .WIDTH_LEN(WL)) dut (
        .clock      (clock),
        .reset      (reset),
        .I_Req      (I_Req),
        .I_St       (I_St),
        .I_Addr     (I_Addr),
        .I_Len      (I_Len),
        .O_Grant    (O_Grant),
        .O_Done     (O_Done),
        .O_Mem_Req  (O_Mem_Req),
        .O_Mem_St   (O_Mem_St),
        .O_Mem_Addr (O_Mem_Addr),
        .O_Mem_Len  (O_Mem_Len),
        .I_Mem_Ack  (I_Mem_Ack),
        .I_Mem_Beat (I_Mem_Beat),
        .O_Busy     (O_Busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: first requesting index searching from exp_ptr upward, wrapping.
    function automatic int rr_pick(input logic [NR-1:0] req);
        for (int k = 0; k < NR; k++) begin
            if (req[(exp_ptr + k) % NR]) return (exp_ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        I_Req      = '0;
        I_Mem_Ack  = 1'b0;
        I_Mem_Beat = 1'b0;
        step();
        reset = 1'b1;
        exp_ptr = 0;
    endtask

    // Len-1 transaction with immediate ack and beat; returns what was observed.
    task automatic serve_len1(output logic [NR-1:0] g, output logic [NR-1:0] d, output logic mr);
        step();
        g  = O_Grant;
        mr = O_Mem_Req;
        I_Mem_Ack = 1'b1;
        step();
        I_Mem_Ack  = 1'b0;
        I_Mem_Beat = 1'b1;
        step();
        I_Mem_Beat = 1'b0;
        d = O_Done;
        step();
    endtask

    task automatic test_reset();
        I_St = '0; I_Addr = '0; I_Len = '0;
        do_reset();
        step();
        total_cnt++; if (O_Grant !== '0) $display("FAIL reset_grant got=%b exp=0", O_Grant); else pass_cnt++;
        total_cnt++; if (O_Done !== '0) $display("FAIL reset_done got=%b exp=0", O_Done); else pass_cnt++;
        total_cnt++;
        if ({O_Mem_Req, O_Mem_St, O_Mem_Addr, O_Mem_Len, O_Busy} !== '0)
            $display("FAIL reset_mem got req=%b st=%b addr=%h len=%h busy=%b exp all 0",
                     O_Mem_Req, O_Mem_St, O_Mem_Addr, O_Mem_Len, O_Busy);
        else pass_cnt++;
        $display("txn reset: outputs checked idle");
    endtask

    task automatic test_single();
        I_Req = 4'b0001; I_St = '0;
        I_Addr[0 +: WA] = 16'h0100; I_Len[0 +: WL] = 8'd3;
        step();
        I_Req = '0;
        total_cnt++; if (O_Grant !== 4'b0001) $display("FAIL single_grant got=%b exp=0001", O_Grant); else pass_cnt++;
        total_cnt++;
        if (O_Mem_Req !== 1'b1 || O_Mem_Addr !== 16'h0100 || O_Mem_Len !== 8'd3 || O_Mem_St !== 1'b0)
            $display("FAIL single_cmd got req=%b addr=%h len=%0d st=%b exp req=1 addr=0100 len=3 st=0",
                     O_Mem_Req, O_Mem_Addr, O_Mem_Len, O_Mem_St);
        else pass_cnt++;
        step();
        total_cnt++; if (O_Mem_Req !== 1'b1) $display("FAIL single_hold_req got=%b exp=1", O_Mem_Req); else pass_cnt++;
        I_Mem_Ack = 1'b1;
        step();
        I_Mem_Ack = 1'b0;
        total_cnt++; if (O_Mem_Req !== 1'b0) $display("FAIL single_req_drop got=%b exp=0", O_Mem_Req); else pass_cnt++;
        I_Mem_Beat = 1'b1;
        step();
        step();
        total_cnt++; if (O_Done !== '0) $display("FAIL single_early_done got=%b exp=0", O_Done); else pass_cnt++;
        step();
        I_Mem_Beat = 1'b0;
        total_cnt++;
        if (O_Done !== 4'b0001 || O_Grant !== 4'b0001)
            $display("FAIL single_done got done=%b grant=%b exp 0001/0001", O_Done, O_Grant);
        else pass_cnt++;
        step();
        total_cnt++;
        if (O_Grant !== '0 || O_Done !== '0 || O_Busy !== 1'b0)
            $display("FAIL single_release got grant=%b done=%b busy=%b exp 0/0/0", O_Grant, O_Done, O_Busy);
        else pass_cnt++;
        exp_ptr = 1;
        $display("txn single: req0 len3 addr0100");
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] g, d;
        logic mr;
        int e;
        do_reset();
        I_Len = {8'd1, 8'd1, 8'd1, 8'd1};
        I_Req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            e = rr_pick(I_Req);
            serve_len1(g, d, mr);
            total_cnt++;
            if (g !== 4'(1 << e) || d !== g || mr !== 1'b1)
                $display("FAIL rr_%0d got grant=%b done=%b mreq=%b exp grant=%b", n, g, d, mr, 4'(1 << e));
            else pass_cnt++;
            exp_ptr = (e + 1) % NR;
            $display("txn rr %0d: grant=%b done=%b", n, g, d);
        end
    endtask

    task automatic test_rotation();
        logic [NR-1:0] g, d;
        logic mr;
        int e;
        I_Req = 4'b0100;
        e = rr_pick(I_Req);
        serve_len1(g, d, mr);
        total_cnt++; if (g !== 4'b0100) $display("FAIL rot_first got=%b exp=0100", g); else pass_cnt++;
        exp_ptr = (e + 1) % NR;
        I_Req = 4'b0101;
        for (int n = 0; n < 4; n++) begin
            e = rr_pick(I_Req);
            serve_len1(g, d, mr);
            total_cnt++;
            if (g !== 4'(1 << e) || d !== g)
                $display("FAIL rot_%0d got grant=%b done=%b exp=%b", n, g, d, 4'(1 << e));
            else pass_cnt++;
            exp_ptr = (e + 1) % NR;
            $display("txn rot %0d: grant=%b", n, g);
        end
    endtask

    task automatic test_zero_len();
        I_Len[1*WL +: WL] = 8'd0;
        I_Req = 4'b0010;
        step();
        I_Req = '0;
        total_cnt++;
        if (O_Grant !== 4'b0010 || O_Done !== '0 || O_Mem_Req !== 1'b0)
            $display("FAIL zero_c1 got grant=%b done=%b mreq=%b exp 0010/0000/0", O_Grant, O_Done, O_Mem_Req);
        else pass_cnt++;
        step();
        total_cnt++;
        if (O_Grant !== 4'b0010 || O_Done !== 4'b0010 || O_Mem_Req !== 1'b0)
            $display("FAIL zero_c2 got grant=%b done=%b mreq=%b exp 0010/0010/0", O_Grant, O_Done, O_Mem_Req);
        else pass_cnt++;
        step();
        total_cnt++; if (O_Grant !== '0) $display("FAIL zero_release got=%b exp=0", O_Grant); else pass_cnt++;
        exp_ptr = 2;
        $display("txn zero: req1 len0");
    endtask

    task automatic test_ignored_beats();
        I_Len[0 +: WL] = 8'd2;
        I_Req = 4'b0001;
        step();
        total_cnt++; if (O_Grant !== 4'b0001) $display("FAIL ign_grant got=%b exp=0001", O_Grant); else pass_cnt++;
        I_Mem_Beat = 1'b1;
        step();
        I_Mem_Ack = 1'b1;
        step();
        I_Mem_Ack = 1'b0; I_Mem_Beat = 1'b0; I_Req = '0;
        total_cnt++;
        if (O_Mem_Req !== 1'b0 || O_Done !== '0)
            $display("FAIL ign_xfer got mreq=%b done=%b exp 0/0", O_Mem_Req, O_Done);
        else pass_cnt++;
        I_Mem_Beat = 1'b1;
        step();
        total_cnt++; if (O_Done !== '0) $display("FAIL ign_one_beat got=%b exp=0", O_Done); else pass_cnt++;
        step();
        I_Mem_Beat = 1'b0;
        total_cnt++; if (O_Done !== 4'b0001) $display("FAIL ign_done got=%b exp=0001", O_Done); else pass_cnt++;
        step();
        exp_ptr = 1;
        $display("txn ignored_beats: req0 len2 dropped req");
    endtask

    task automatic test_reset_mid();
        I_Len[1*WL +: WL] = 8'd6;
        I_Req = 4'b0010;
        step();
        I_Req = '0;
        I_Mem_Ack = 1'b1;
        step();
        I_Mem_Ack = 1'b0; I_Mem_Beat = 1'b1;
        step();
        I_Mem_Beat = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        total_cnt++;
        if (O_Grant !== '0 || O_Done !== '0 || O_Mem_Req !== 1'b0 || O_Busy !== 1'b0 ||
            O_Mem_Addr !== '0 || O_Mem_Len !== '0)
            $display("FAIL rstmid_outputs got grant=%b done=%b mreq=%b busy=%b addr=%h len=%h exp all 0",
                     O_Grant, O_Done, O_Mem_Req, O_Busy, O_Mem_Addr, O_Mem_Len);
        else pass_cnt++;
        exp_ptr = 0;
        I_Len[3*WL +: WL] = 8'd1;
        I_Req = 4'b1000;
        step();
        I_Req = '0;
        total_cnt++; if (O_Grant !== 4'b1000) $display("FAIL rstmid_grant got=%b exp=1000", O_Grant); else pass_cnt++;
        I_Mem_Ack = 1'b1; step(); I_Mem_Ack = 1'b0;
        I_Mem_Beat = 1'b1; step(); I_Mem_Beat = 1'b0;
        total_cnt++; if (O_Done !== 4'b1000) $display("FAIL rstmid_done got=%b exp=1000", O_Done); else pass_cnt++;
        step();
        exp_ptr = 0;
        $display("txn reset_mid: aborted then req3 granted");
    endtask

    task automatic test_random();
        logic [NR-1:0]  req;
        logic [WA-1:0]  ea;
        logic [WL-1:0]  el;
        logic           es;
        int e, beats, budget, ackd;
        for (int n = 0; n < 40; n++) begin
            req = 4'($urandom_range(0, 15));
            for (int i = 0; i < NR; i++) begin
                I_Addr[i*WA +: WA] = 16'($urandom);
                I_Len[i*WL +: WL]  = 8'($urandom_range(0, 5));
            end
            I_St  = 4'($urandom);
            I_Req = req;
            e = rr_pick(req);
            step();
            if (e < 0) begin
                total_cnt++;
                if (O_Grant !== '0 || O_Busy !== 1'b0)
                    $display("FAIL rnd%0d_idle got grant=%b busy=%b exp 0/0", n, O_Grant, O_Busy);
                else pass_cnt++;
                $display("txn rnd %0d: no request", n);
                continue;
            end
            ea = I_Addr[e*WA +: WA];
            el = I_Len[e*WL +: WL];
            es = I_St[e];
            // Scramble inputs: none of this may affect the granted burst.
            I_Req  = 4'($urandom);
            I_Addr = {$urandom, $urandom};
            I_Len  = $urandom;
            total_cnt++;
            if (O_Grant !== 4'(1 << e) || O_Mem_Addr !== ea || O_Mem_Len !== el || O_Mem_St !== es ||
                O_Mem_Req !== (el != 0))
                $display("FAIL rnd%0d_grant got grant=%b addr=%h len=%0d st=%b mreq=%b exp grant=%b addr=%h len=%0d st=%b",
                         n, O_Grant, O_Mem_Addr, O_Mem_Len, O_Mem_St, O_Mem_Req, 4'(1 << e), ea, el, es);
            else pass_cnt++;
            beats = 0;
            if (el != 0) begin
                ackd = $urandom_range(0, 3);
                for (int c = 0; c < ackd; c++) begin
                    I_Mem_Beat = 1'($urandom);
                    step();
                end
                I_Mem_Ack  = 1'b1;
                I_Mem_Beat = 1'($urandom);
                step();
                I_Mem_Ack = 1'b0;
                budget = 0;
                while (O_Done === '0 && budget < 200) begin
                    I_Mem_Beat = 1'($urandom);
                    step();
                    if (I_Mem_Beat) beats++;
                    budget++;
                end
                I_Mem_Beat = 1'b0;
                if (budget >= 200) begin
                    total_cnt++;
                    $display("FAIL rnd%0d_timeout got no done after %0d cycles exp done", n, budget);
                end
            end else begin
                step();
            end
            total_cnt++;
            if (O_Done !== 4'(1 << e) || beats !== int'(el))
                $display("FAIL rnd%0d_done got done=%b beats=%0d exp done=%b beats=%0d",
                         n, O_Done, beats, 4'(1 << e), el);
            else pass_cnt++;
            step();
            total_cnt++;
            if (O_Grant !== '0 || O_Busy !== 1'b0)
                $display("FAIL rnd%0d_release got grant=%b busy=%b exp 0/0", n, O_Grant, O_Busy);
            else pass_cnt++;
            exp_ptr = (e + 1) % NR;
            $display("txn rnd %0d: req=%b grant=%0d len=%0d beats=%0d", n, req, e, el, beats);
        end
        I_Req = '0;
    endtask

    initial begin
        reset = 1'b0; I_Req = '0; I_St = '0; I_Addr = '0; I_Len = '0;
        I_Mem_Ack = 1'b0; I_Mem_Beat = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_rotation();
        test_zero_len();
        test_ignored_beats();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
